// File: rtl/debouncer_multi_if.sv
// ---------------------------------------------------------------------------
// debouncer_multi_if
//   Bundles the per-channel signals of debouncer_multi.
//   master : the side that drives raw inputs and consumes debounced results
//   slave  : the debouncer itself
// Signals:
//   i_pulse   [NUM_CH] raw asynchronous inputs, bit n is channel n
//   o_pulse   [NUM_CH] debounced stable levels
//   o_rise    [NUM_CH] one-cycle strobe on a 0->1 change of o_pulse[n]
//   o_fall    [NUM_CH] one-cycle strobe on a 1->0 change of o_pulse[n]
//   o_changed          OR of all rise/fall strobes, aligned with them
// ---------------------------------------------------------------------------
interface debouncer_multi_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0] i_pulse;
  logic [NUM_CH-1:0] o_pulse;
  logic [NUM_CH-1:0] o_rise;
  logic [NUM_CH-1:0] o_fall;
  logic              o_changed;

  modport master (
    output i_pulse,
    input  o_pulse,
    input  o_rise,
    input  o_fall,
    input  o_changed
  );

  modport slave (
    input  i_pulse,
    output o_pulse,
    output o_rise,
    output o_fall,
    output o_changed
  );
endinterface

// File: rtl/debouncer_multi.sv
// ---------------------------------------------------------------------------
// debouncer_multi
//   NUM_CH independent switch debouncers sharing one prescaler. Each raw
//   input passes through a SYNC_STAGES-deep synchroniser; the debounced level
//   only follows the synchronised input once it has disagreed with the
//   current level for DEBOUNCE_CNT_LIMIT consecutive prescaler ticks. Any
//   return to the stable level restarts that channel's count.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  debouncer_multi_if.slave: i_pulse in; o_pulse, o_rise, o_fall,
//        o_changed out (all outputs registered)
// ---------------------------------------------------------------------------
module debouncer_multi #(
  parameter int unsigned NUM_CH             = 4,
  parameter int unsigned DEBOUNCE_CNT_LIMIT = 500,
  parameter int unsigned PRESCALE           = 1000,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter logic        RESET_LEVEL        = 1'b0
) (
  input logic              clk,
  input logic              rst,
  debouncer_multi_if.slave bus
);

  localparam int unsigned CW = (DEBOUNCE_CNT_LIMIT > 1) ? $clog2(DEBOUNCE_CNT_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT_LIMIT - 1);

  // -------------------------------------------------------------------------
  // Shared prescaler
  // -------------------------------------------------------------------------
  logic tick;

  if (PRESCALE == 1) begin : g_no_prescale
    assign tick = 1'b1;
  end else begin : g_prescale
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] ps_cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        ps_cnt <= '0;
      end else if (ps_cnt == PS_LAST) begin
        ps_cnt <= '0;
      end else begin
        ps_cnt <= ps_cnt + PW'(1);
      end
    end

    assign tick = (ps_cnt == PS_LAST);
  end

  // -------------------------------------------------------------------------
  // Input synchronisers: plain flop chain, nothing between stages
  // -------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync [SYNC_STAGES];
  logic [NUM_CH-1:0] s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync[i] <= {NUM_CH{RESET_LEVEL}};
      end
    end else begin
      sync[0] <= bus.i_pulse;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Per-channel debounce counters and output registers
  // -------------------------------------------------------------------------
  logic [CW-1:0]     cnt      [NUM_CH];
  logic [CW-1:0]     cnt_nxt  [NUM_CH];
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] pulse_nxt;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] rise_nxt;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] fall_nxt;
  logic              changed;

  always_comb begin
    cnt_nxt   = cnt;
    pulse_nxt = pulse;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (s[n] == pulse[n]) begin
        // Agreement, even for one cycle, discards any partial count.
        cnt_nxt[n] = '0;
      end else if (tick) begin
        if (cnt[n] == CNT_LAST) begin
          pulse_nxt[n] = s[n];
          cnt_nxt[n]   = '0;
          rise_nxt[n]  = s[n];
          fall_nxt[n]  = ~s[n];
        end else begin
          cnt_nxt[n] = cnt[n] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cnt[n] <= '0;
      end
      pulse   <= {NUM_CH{RESET_LEVEL}};
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      pulse   <= pulse_nxt;
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      // Built from the next-state strobes so it lands in the same cycle.
      changed <= |(rise_nxt | fall_nxt);
    end
  end

  assign bus.o_pulse   = pulse;
  assign bus.o_rise    = rise;
  assign bus.o_fall    = fall;
  assign bus.o_changed = changed;

endmodule

// File: tb/tb_debouncer_multi.sv
// ---------------------------------------------------------------------------
// tb_debouncer_multi
//   dut_a: NUM_CH=4, LIMIT=8, PRESCALE=1, SYNC=2, RESET_LEVEL=0
//   dut_b: NUM_CH=4, LIMIT=3, PRESCALE=4, SYNC=2, RESET_LEVEL=1
//   The reference model keeps the full history of synchronised inputs and
//   ticks since reset and decides each edge by scanning back over the current
//   run of disagreement, counting ticks in it.
// ---------------------------------------------------------------------------
module tb_debouncer_multi;

  localparam int SYNC = 2;
  localparam int HDEPTH = 8192;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] ina, inb;

  int n_checks = 0;
  int n_fail   = 0;
  int kb       = 0;

  always #5 clk = ~clk;

  debouncer_multi_if #(.NUM_CH(4)) bus_a ();
  debouncer_multi_if #(.NUM_CH(4)) bus_b ();

  assign bus_a.i_pulse = ina;
  assign bus_b.i_pulse = inb;

  debouncer_multi #(
    .NUM_CH(4), .DEBOUNCE_CNT_LIMIT(8), .PRESCALE(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );

  debouncer_multi #(
    .NUM_CH(4), .DEBOUNCE_CNT_LIMIT(3), .PRESCALE(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  // ------------------------------------------------------------------ model
  logic [3:0] in_hist [2][HDEPTH];
  logic [3:0] s_hist  [2][HDEPTH];
  bit         t_hist  [2][HDEPTH];
  int         e_idx   [2];
  int         lastf   [2][4];
  logic [3:0] m_o     [2];
  logic [3:0] m_rise  [2];
  logic [3:0] m_fall  [2];
  logic       m_chg   [2];

  function automatic int p_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int l_of(input int d);
    return (d == 0) ? 8 : 3;
  endfunction

  function automatic logic [3:0] rl_of(input int d);
    return (d == 0) ? 4'h0 : 4'hF;
  endfunction

  task automatic model_step(input int d, input logic [3:0] x, input logic r);
    int         e;
    int         cnt;
    bit         t;
    logic [3:0] s;
    logic [3:0] flips;
    if (r) begin
      e_idx[d]  = 0;
      m_o[d]    = rl_of(d);
      m_rise[d] = '0;
      m_fall[d] = '0;
      m_chg[d]  = 1'b0;
      for (int n = 0; n < 4; n++) lastf[d][n] = -1;
      return;
    end
    e = e_idx[d];
    if (e >= HDEPTH) begin
      $display("FAIL model_history: index %0d exceeds depth %0d", e, HDEPTH);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "model history overflow");
    end
    s = (e >= SYNC) ? in_hist[d][e-SYNC] : rl_of(d);
    t = ((e % p_of(d)) == p_of(d) - 1);
    in_hist[d][e] = x;
    s_hist[d][e]  = s;
    t_hist[d][e]  = t;
    flips = '0;
    for (int n = 0; n < 4; n++) begin
      if (t && s[n] != m_o[d][n]) begin
        cnt = 0;
        for (int j = e; j > lastf[d][n]; j--) begin
          if (s_hist[d][j][n] == m_o[d][n]) break;
          if (t_hist[d][j]) cnt++;
        end
        if (cnt == l_of(d)) begin
          flips[n] = 1'b1;
          lastf[d][n] = e;
        end
      end
    end
    m_o[d]    = m_o[d] ^ flips;
    m_rise[d] = flips & m_o[d];
    m_fall[d] = flips & ~m_o[d];
    m_chg[d]  = |flips;
    e_idx[d]  = e + 1;
  endtask

  // One clock edge; outputs are read at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0, ina, rst_a);
    model_step(1, inb, rst_b);
    if (rst_b) kb = 0;
    else kb++;
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; ina = 4'h0; inb = 4'hF;
    repeat (3) cycle();
    n_checks++;
    if (bus_a.o_pulse !== 4'h0 || bus_a.o_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_a: o_pulse=%h o_changed=%b, required 0 0", bus_a.o_pulse, bus_a.o_changed);
    end
    n_checks++;
    if (bus_b.o_pulse !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_b_level: o_pulse=%h, required f", bus_b.o_pulse);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    for (int r = 1; r <= 20; r++) begin
      cycle();
      n_checks++;
      if (bus_b.o_pulse !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_b_hold edge %0d: o_pulse=%h, required f", r, bus_b.o_pulse);
      end
      n_checks++;
      if ({bus_b.o_rise, bus_b.o_fall, bus_b.o_changed} !== 9'b0 ||
          {bus_a.o_rise, bus_a.o_fall, bus_a.o_changed} !== 9'b0) begin
        n_fail++;
        $display("FAIL reset_no_strobe edge %0d: b rise=%h fall=%h chg=%b a rise=%h fall=%h chg=%b, required all 0",
                 r, bus_b.o_rise, bus_b.o_fall, bus_b.o_changed, bus_a.o_rise, bus_a.o_fall, bus_a.o_changed);
      end
    end
  endtask

  task automatic test_single_rise();
    ina = 4'b0001;
    for (int r = 1; r <= 14; r++) begin
      cycle();
      n_checks++;
      if (bus_a.o_pulse !== ((r >= 10) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_rise_level edge %0d: o_pulse=%h, required %h", r, bus_a.o_pulse,
                 (r >= 10) ? 4'b0001 : 4'b0000);
      end
      n_checks++;
      if (bus_a.o_rise !== ((r == 10) ? 4'b0001 : 4'b0000) || bus_a.o_fall !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_rise_strobe edge %0d: o_rise=%h o_fall=%h, required %h 0", r,
                 bus_a.o_rise, bus_a.o_fall, (r == 10) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] ep, er;
    for (int r = 1; r <= 24; r++) begin
      ina[1] = (r <= 5 || r >= 8);
      cycle();
      ep = 4'b0001 | ((r >= 17) ? 4'b0010 : 4'b0000);
      er = (r == 17) ? 4'b0010 : 4'b0000;
      n_checks++;
      if (bus_a.o_pulse !== ep || bus_a.o_rise !== er) begin
        n_fail++;
        $display("FAIL glitch edge %0d: o_pulse=%h o_rise=%h, required %h %h", r, bus_a.o_pulse, bus_a.o_rise, ep, er);
      end
    end
  endtask

  task automatic test_simultaneous();
    rst_a = 1'b1; ina = 4'h0;
    cycle();
    rst_a = 1'b0;
    repeat (4) cycle();
    ina = 4'b1001;
    for (int r = 1; r <= 14; r++) begin
      cycle();
      n_checks++;
      if (bus_a.o_rise !== ((r == 10) ? 4'b1001 : 4'b0000) || bus_a.o_changed !== (r == 10)) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d: o_rise=%h o_changed=%b, required %h %b", r, bus_a.o_rise,
                 bus_a.o_changed, (r == 10) ? 4'b1001 : 4'b0000, (r == 10));
      end
      n_checks++;
      if (bus_a.o_pulse !== ((r >= 10) ? 4'b1001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL simultaneous_level edge %0d: o_pulse=%h, required %h", r, bus_a.o_pulse,
                 (r >= 10) ? 4'b1001 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    rst_a = 1'b1; ina = 4'h0;
    cycle();
    rst_a = 1'b0;
    repeat (4) cycle();
    ina = 4'b0001;
    // After edge 8 channel 0 has counted 6 ticks.
    repeat (8) cycle();
    rst_a = 1'b1;
    cycle();
    n_checks++;
    if (bus_a.o_pulse !== 4'h0 || {bus_a.o_rise, bus_a.o_fall, bus_a.o_changed} !== 9'b0) begin
      n_fail++;
      $display("FAIL mid_count_reset: o_pulse=%h rise=%h fall=%h chg=%b, required 0", bus_a.o_pulse,
               bus_a.o_rise, bus_a.o_fall, bus_a.o_changed);
    end
    rst_a = 1'b0;
    for (int r = 1; r <= 13; r++) begin
      cycle();
      n_checks++;
      if (bus_a.o_pulse !== ((r >= 10) ? 4'b0001 : 4'b0000) ||
          bus_a.o_rise !== ((r == 10) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL mid_count_restart edge %0d: o_pulse=%h o_rise=%h, required %h %h", r, bus_a.o_pulse,
                 bus_a.o_rise, (r >= 10) ? 4'b0001 : 4'b0000, (r == 10) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_fall_prescaled();
    int nfall;
    inb = 4'hF;
    for (int w = 0; w < 4 && (kb % 4) != 2; w++) cycle();
    // Next edge is prescaler phase 2, so ticks land on relative edges 2,6,10,14.
    inb = 4'b1011;
    nfall = 0;
    for (int r = 1; r <= 20; r++) begin
      cycle();
      if (bus_b.o_fall[2] === 1'b1) nfall++;
      n_checks++;
      if (bus_b.o_fall !== ((r == 14) ? 4'b0100 : 4'b0000) || bus_b.o_rise !== 4'b0000) begin
        n_fail++;
        $display("FAIL fall_prescaled edge %0d: o_fall=%h o_rise=%h, required %h 0", r, bus_b.o_fall,
                 bus_b.o_rise, (r == 14) ? 4'b0100 : 4'b0000);
      end
      n_checks++;
      if (bus_b.o_pulse !== ((r >= 14) ? 4'b1011 : 4'b1111)) begin
        n_fail++;
        $display("FAIL fall_prescaled_level edge %0d: o_pulse=%h, required %h", r, bus_b.o_pulse,
                 (r >= 14) ? 4'b1011 : 4'b1111);
      end
    end
    n_checks++;
    if (nfall != 1) begin
      n_fail++;
      $display("FAIL fall_width: o_fall[2] high for %0d cycles, required 1", nfall);
    end
  endtask

  task automatic test_random();
    int pct;
    rst_a = 1'b1; rst_b = 1'b1;
    cycle();
    rst_a = 1'b0; rst_b = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      case ((c / 150) % 3)
        0:       pct = 2;
        1:       pct = 10;
        default: pct = 35;
      endcase
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 99) < pct) ina[n] = ~ina[n];
        if ($urandom_range(0, 99) < pct) inb[n] = ~inb[n];
      end
      rst_a = ($urandom_range(0, 299) == 0);
      rst_b = ($urandom_range(0, 299) == 0);
      cycle();
      n_checks++;
      if (bus_a.o_pulse !== m_o[0] || bus_a.o_rise !== m_rise[0] ||
          bus_a.o_fall !== m_fall[0] || bus_a.o_changed !== m_chg[0]) begin
        n_fail++;
        $display("FAIL random_a cycle %0d: pulse=%h rise=%h fall=%h chg=%b, required %h %h %h %b", c,
                 bus_a.o_pulse, bus_a.o_rise, bus_a.o_fall, bus_a.o_changed,
                 m_o[0], m_rise[0], m_fall[0], m_chg[0]);
      end
      n_checks++;
      if (bus_b.o_pulse !== m_o[1] || bus_b.o_rise !== m_rise[1] ||
          bus_b.o_fall !== m_fall[1] || bus_b.o_changed !== m_chg[1]) begin
        n_fail++;
        $display("FAIL random_b cycle %0d: pulse=%h rise=%h fall=%h chg=%b, required %h %h %h %b", c,
                 bus_b.o_pulse, bus_b.o_rise, bus_b.o_fall, bus_b.o_changed,
                 m_o[1], m_rise[1], m_fall[1], m_chg[1]);
      end
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; ina = 4'h0; inb = 4'hF;
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_reset_mid_count();
    test_fall_prescaled();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
